// File: rtl/if_id_stage_if.sv
// Bus interface between the fetch/hazard side and the if_id_stage block.
// The stage itself connects through the slave modport; whoever drives the
// next PC, the imem read data and the hazard controls uses the master modport.
// Optional feature macro: IF_ID_PERF_CNT_EN adds the stall/flush counter outputs.
interface if_id_stage_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc_next_i;
    logic [31:0]      instr_f_i;
    logic             stall_f_i;
    logic             stall_d_i;
    logic             flush_d_i;
    logic [WIDTH-1:0] pc_f_o;
    logic [WIDTH-1:0] pc_plus4_f_o;
    logic [31:0]      instr_d_o;
    logic [WIDTH-1:0] pc_d_o;
    logic [WIDTH-1:0] pc_plus4_d_o;
    logic             valid_d_o;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0]      stall_cnt_o;
    logic [31:0]      flush_cnt_o;

    modport slave (
        input  pc_next_i, instr_f_i, stall_f_i, stall_d_i, flush_d_i,
        output pc_f_o, pc_plus4_f_o, instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o,
        output stall_cnt_o, flush_cnt_o
    );

    modport master (
        output pc_next_i, instr_f_i, stall_f_i, stall_d_i, flush_d_i,
        input  pc_f_o, pc_plus4_f_o, instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o,
        input  stall_cnt_o, flush_cnt_o
    );
`else
    modport slave (
        input  pc_next_i, instr_f_i, stall_f_i, stall_d_i, flush_d_i,
        output pc_f_o, pc_plus4_f_o, instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o
    );

    modport master (
        output pc_next_i, instr_f_i, stall_f_i, stall_d_i, flush_d_i,
        input  pc_f_o, pc_plus4_f_o, instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o
    );
`endif
endinterface

// File: rtl/if_id_stage.sv
// Fetch PC register plus IF/ID pipeline register of the 5-stage RV32I core.
// The PC register feeds the imem address and the PC+4 adder; the IF/ID register
// hands the fetched instruction and its PC to Decode under hazard-unit control
// (flush beats stall beats load). All outputs come straight from flops or from
// the PC+4 adder, so stall/flush never reach an output combinationally.
// Optional feature macro: IF_ID_PERF_CNT_EN adds saturating stall/flush counters.
module if_id_stage #(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset_n,
    if_id_stage_if.slave  bus
);

    // Clears the two low PC bits; misaligned targets are silently aligned here.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);

    logic [WIDTH-1:0] fetchPc_q,     fetchPc_d;
    logic [31:0]      decInstr_q,    decInstr_d;
    logic [WIDTH-1:0] decPc_q,       decPc_d;
    logic [WIDTH-1:0] decPcPlus4_q,  decPcPlus4_d;
    logic             decValid_q,    decValid_d;
    logic [WIDTH-1:0] fetchPcPlus4;

    // PC+4 adder, wraps modulo 2^WIDTH.
    always_comb begin
        fetchPcPlus4 = fetchPc_q + PC_STEP;
    end

    // Next fetch PC: hold on fetch stall, otherwise take the aligned mux output.
    always_comb begin
        fetchPc_d = fetchPc_q;
        if (!bus.stall_f_i) begin
            fetchPc_d = bus.pc_next_i & ALIGN_MASK;
        end
    end

    // Next IF/ID contents: a flush inserts a bubble even while Decode is stalled.
    always_comb begin
        decInstr_d   = decInstr_q;
        decPc_d      = decPc_q;
        decPcPlus4_d = decPcPlus4_q;
        decValid_d   = decValid_q;
        if (bus.flush_d_i) begin
            decInstr_d   = NOP_INSTR;
            decPc_d      = '0;
            decPcPlus4_d = '0;
            decValid_d   = 1'b0;
        end else if (!bus.stall_d_i) begin
            decInstr_d   = bus.instr_f_i;
            decPc_d      = fetchPc_q;
            decPcPlus4_d = fetchPcPlus4;
            decValid_d   = 1'b1;
        end
    end

    // PC register with asynchronous reset to the boot address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetchPc_q <= RESET_PC;
        end else begin
            fetchPc_q <= fetchPc_d;
        end
    end

    // IF/ID register; reset leaves a bubble in Decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            decInstr_q   <= NOP_INSTR;
            decPc_q      <= '0;
            decPcPlus4_q <= '0;
            decValid_q   <= 1'b0;
        end else begin
            decInstr_q   <= decInstr_d;
            decPc_q      <= decPc_d;
            decPcPlus4_q <= decPcPlus4_d;
            decValid_q   <= decValid_d;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stallCnt_q, stallCnt_d;
    logic [31:0] flushCnt_q, flushCnt_d;

    // Event counters stop at all-ones instead of wrapping; a stall that is
    // overridden by a flush counts only as a flush.
    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (bus.flush_d_i) begin
            if (flushCnt_q != '1) begin
                flushCnt_d = flushCnt_q + 32'd1;
            end
        end else if (bus.stall_d_i) begin
            if (stallCnt_q != '1) begin
                stallCnt_d = stallCnt_q + 32'd1;
            end
        end
    end

    // Counter registers, cleared by the same asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign bus.stall_cnt_o = stallCnt_q;
    assign bus.flush_cnt_o = flushCnt_q;
`endif

    assign bus.pc_f_o       = fetchPc_q;
    assign bus.pc_plus4_f_o = fetchPcPlus4;
    assign bus.instr_d_o    = decInstr_q;
    assign bus.pc_d_o       = decPc_q;
    assign bus.pc_plus4_d_o = decPcPlus4_q;
    assign bus.valid_d_o    = decValid_q;

endmodule
